// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the CSR-mapped interrupt controller: bus widths and register offsets.
package irq_ctrl_pkg;

  localparam int unsigned CSR_AW = 8;
  localparam int unsigned CSR_DW = 8;

  typedef logic [CSR_AW-1:0] csr_addr_t;
  typedef logic [CSR_DW-1:0] csr_data_t;

  localparam csr_addr_t IRQ_STATUS = 8'd0;
  localparam csr_addr_t IRQ_IE     = 8'd1;
  localparam csr_addr_t IRQ_IP     = 8'd2;
  localparam csr_addr_t IRQ_EDGE   = 8'd3;
  localparam csr_addr_t IRQ_POL    = 8'd4;

endpackage

// File: rtl/irq_ctrl_if.sv
// Shared CSR bus: the I2C slave side is the master; register blocks are slaves.
interface irq_ctrl_if;

  irq_ctrl_pkg::csr_addr_t csr_a;
  logic                    csr_we;
  irq_ctrl_pkg::csr_data_t csr_di;
  irq_ctrl_pkg::csr_data_t csr_do;

  modport master (output csr_a, output csr_we, output csr_di, input csr_do);
  modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for one asynchronous input, plus single-cycle rise/fall pulses
// derived from the synchronized level.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches up to 8 synchronized sources into pending bits (edge or
// level, selectable polarity) and drives one registered, IE-masked request line.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [CSR_AW-1:0] BASE_ADDR = 8'h10,
  parameter int unsigned       NUM_IRQ   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  irq_ctrl_if.slave          csr,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  logic [NUM_IRQ-1:0] ie_q, ip_q, ip_d, edge_q, pol_q;
  logic [NUM_IRQ-1:0] level, rise, fall, set;
  csr_addr_t          off;
  csr_data_t          rdata, rdata_q;
  logic               we_ie, we_ip, we_edge, we_pol;
  logic               irq_q;

  // Offset wraps modulo 256, so off <= 4 is exactly BASE_ADDR..BASE_ADDR+4.
  assign off     = csr.csr_a - BASE_ADDR;
  assign we_ie   = csr.csr_we && (off == IRQ_IE);
  assign we_ip   = csr.csr_we && (off == IRQ_IP);
  assign we_edge = csr.csr_we && (off == IRQ_EDGE);
  assign we_pol  = csr.csr_we && (off == IRQ_POL);

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
    sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (irq_in[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );

    assign set[i]  = edge_q[i] ? (pol_q[i] ? rise[i] : fall[i]) : (level[i] == pol_q[i]);
    // Set beats a same-cycle W1C.
    assign ip_d[i] = set[i] | (ip_q[i] & ~(we_ip & csr.csr_di[i]));
  end

  if (NUM_IRQ < CSR_DW) begin : g_narrow
    logic unused_di;
    assign unused_di = ^csr.csr_di[CSR_DW-1:NUM_IRQ];
  end

  always_comb begin
    rdata = '0;
    case (off)
      IRQ_STATUS: rdata = CSR_DW'(level);
      IRQ_IE:     rdata = CSR_DW'(ie_q);
      IRQ_IP:     rdata = CSR_DW'(ip_q);
      IRQ_EDGE:   rdata = CSR_DW'(edge_q);
      IRQ_POL:    rdata = CSR_DW'(pol_q);
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q    <= '0;
      ip_q    <= '0;
      edge_q  <= '0;
      pol_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (we_ie)   ie_q   <= csr.csr_di[NUM_IRQ-1:0];
      if (we_edge) edge_q <= csr.csr_di[NUM_IRQ-1:0];
      if (we_pol)  pol_q  <= csr.csr_di[NUM_IRQ-1:0];
      ip_q    <= ip_d;
      rdata_q <= rdata;
      irq_q   <= |(ip_q & ie_q);
    end
  end

  assign csr.csr_do = rdata_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a register/decode vector table plus hand-timed sequences.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam logic [7:0] BASE = 8'h10;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic       exp_irq;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in = '0;
  logic       irq;
  logic [3:0] irq_in4 = '0;
  logic       irq4;

  int total = 0;
  int bad   = 0;

  irq_ctrl_if bus ();
  irq_ctrl_if bus4 ();

  irq_ctrl #(.BASE_ADDR(BASE), .NUM_IRQ(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .csr    (bus.slave),
    .irq_in (irq_in),
    .irq    (irq)
  );

  irq_ctrl #(.BASE_ADDR(BASE), .NUM_IRQ(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .csr    (bus4.slave),
    .irq_in (irq_in4),
    .irq    (irq4)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  task automatic csr_write(input logic [7:0] a, input logic [7:0] d);
    bus.csr_a  = a;
    bus.csr_di = d;
    bus.csr_we = 1'b1;
    tick(1);
    bus.csr_we = 1'b0;
  endtask

  task automatic csr_read(input logic [7:0] a, output logic [7:0] d);
    bus.csr_a = a;
    tick(1);
    d = bus.csr_do;
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] off, input logic [7:0] wd,
                              input logic [7:0] rd);
    vec_t v;
    v.wr      = wr;
    v.addr    = (off == 8'hFF) ? 8'h00 : 8'(BASE + off);
    v.wdata   = wd;
    v.exp_rd  = rd;
    v.exp_irq = 1'b0;
    return v;
  endfunction

  vec_t       vecs[17];
  logic [7:0] rd;

  initial begin
    // Offset 8'hFF stands for absolute address 0x00.
    vecs[0]  = mk(1'b0, 8'd0, 8'h00, 8'h00);
    vecs[1]  = mk(1'b0, 8'd1, 8'h00, 8'h00);
    vecs[2]  = mk(1'b0, 8'd3, 8'h00, 8'h00);
    vecs[3]  = mk(1'b0, 8'd4, 8'h00, 8'h00);
    // Reset config is level/low-active and irq_in is low, so every source latches.
    vecs[4]  = mk(1'b0, 8'd2, 8'h00, 8'hFF);
    vecs[5]  = mk(1'b1, 8'd3, 8'hFF, 8'hFF);
    vecs[6]  = mk(1'b1, 8'd4, 8'hFF, 8'hFF);
    vecs[7]  = mk(1'b1, 8'd2, 8'hFF, 8'h00);
    vecs[8]  = mk(1'b1, 8'd2, 8'h00, 8'h00);
    vecs[9]  = mk(1'b1, 8'd0, 8'hAA, 8'h00);
    vecs[10] = mk(1'b1, 8'd5, 8'hAA, 8'h00);
    vecs[11] = mk(1'b1, 8'hFF, 8'hAA, 8'h00);
    vecs[12] = mk(1'b0, 8'd1, 8'h00, 8'h00);
    vecs[13] = mk(1'b0, 8'd3, 8'h00, 8'hFF);
    vecs[14] = mk(1'b0, 8'd4, 8'h00, 8'hFF);
    vecs[15] = mk(1'b1, 8'd1, 8'h5A, 8'h5A);
    vecs[16] = mk(1'b1, 8'd1, 8'h00, 8'h00);

    bus.csr_a   = BASE;
    bus.csr_we  = 1'b0;
    bus.csr_di  = '0;
    bus4.csr_a  = BASE;
    bus4.csr_we = 1'b0;
    bus4.csr_di = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_irq_async", {7'd0, irq}, 8'h00);
    check("reset_do_async", bus.csr_do, 8'h00);

    for (int i = 0; i < 5; i++) begin
      bus.csr_a = 8'(BASE + i);
      tick(1);
      check($sformatf("reset_rd_%0d", i), bus.csr_do, 8'h00);
    end
    rst_n = 1'b1;
    tick(2);

    foreach (vecs[i]) begin
      if (vecs[i].wr) csr_write(vecs[i].addr, vecs[i].wdata);
      csr_read(vecs[i].addr, rd);
      check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {7'd0, irq}, {7'd0, vecs[i].exp_irq});
    end

    // Four-source instance: the upper nibble reads back as zero.
    bus4.csr_a  = 8'(BASE + 1);
    bus4.csr_di = 8'hFF;
    bus4.csr_we = 1'b1;
    tick(1);
    bus4.csr_we = 1'b0;
    tick(1);
    check("n4_ie", bus4.csr_do, 8'h0F);
    bus4.csr_a = 8'(BASE + 3);
    bus4.csr_we = 1'b1;
    tick(1);
    bus4.csr_we = 1'b0;
    tick(1);
    check("n4_edge", bus4.csr_do, 8'h0F);

    // Edge rising, source 2: two sync flops + pending flop + irq flop.
    csr_write(8'(BASE + 1), 8'h04);
    irq_in[2] = 1'b1;
    tick(3);
    check("edge_irq_early", {7'd0, irq}, 8'h00);
    tick(1);
    check("edge_irq_set", {7'd0, irq}, 8'h01);
    irq_in[2] = 1'b0;
    csr_read(8'(BASE + 2), rd);
    check("edge_ip", rd, 8'h04);
    csr_write(8'(BASE + 2), 8'h04);
    check("edge_w1c_irq_hold", {7'd0, irq}, 8'h01);
    tick(1);
    check("edge_w1c_irq_low", {7'd0, irq}, 8'h00);
    csr_read(8'(BASE + 2), rd);
    check("edge_w1c_ip", rd, 8'h00);

    // Level low-active, source 0.
    csr_write(8'(BASE + 4), 8'hFE);
    csr_write(8'(BASE + 3), 8'hFE);
    csr_write(8'(BASE + 1), 8'h01);
    csr_read(8'(BASE + 2), rd);
    check("lvl_ip", rd, 8'h01);
    check("lvl_irq", {7'd0, irq}, 8'h01);
    csr_write(8'(BASE + 2), 8'h01);
    csr_read(8'(BASE + 2), rd);
    check("lvl_w1c_active", rd, 8'h01);
    irq_in[0] = 1'b1;
    tick(4);
    csr_read(8'(BASE + 0), rd);
    check("lvl_status", rd, 8'h01);
    csr_write(8'(BASE + 2), 8'h01);
    csr_read(8'(BASE + 2), rd);
    check("lvl_w1c_inactive", rd, 8'h00);
    check("lvl_irq_low", {7'd0, irq}, 8'h00);

    // Collision on source 5: rise pulse and W1C land on the same edge.
    irq_in[5] = 1'b1;
    tick(2);
    csr_write(8'(BASE + 2), 8'h20);
    csr_read(8'(BASE + 2), rd);
    check("collide_ip", rd, 8'h20);
    irq_in[5] = 1'b0;
    tick(3);
    csr_write(8'(BASE + 2), 8'h20);
    csr_read(8'(BASE + 2), rd);
    check("collide_clear", rd, 8'h00);

    // IE masking, source 1.
    csr_write(8'(BASE + 1), 8'h00);
    irq_in[1] = 1'b1;
    tick(4);
    irq_in[1] = 1'b0;
    tick(3);
    check("mask_irq_off", {7'd0, irq}, 8'h00);
    csr_read(8'(BASE + 2), rd);
    check("mask_ip", rd, 8'h02);
    csr_write(8'(BASE + 1), 8'h02);
    check("mask_irq_lag", {7'd0, irq}, 8'h00);
    tick(1);
    check("mask_irq_on", {7'd0, irq}, 8'h01);

    // Falling edge on source 3: rising must not latch.
    csr_write(8'(BASE + 4), 8'hF6);
    irq_in[3] = 1'b1;
    tick(4);
    csr_read(8'(BASE + 2), rd);
    check("fall_no_rise", rd, 8'h02);
    irq_in[3] = 1'b0;
    tick(4);
    csr_read(8'(BASE + 2), rd);
    check("fall_ip", rd, 8'h0A);

    // Asynchronous reset mid-cycle with live outputs.
    check("pre_rst_irq", {7'd0, irq}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_irq", {7'd0, irq}, 8'h00);
    check("midrst_do", bus.csr_do, 8'h00);
    tick(1);
    rst_n = 1'b1;
    csr_read(8'(BASE + 1), rd);
    check("midrst_ie", rd, 8'h00);
    csr_read(8'(BASE + 4), rd);
    check("midrst_pol", rd, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
